call_latch_ctrl: RTL and testbench
==================================

CALL_LATCH_CTRL -- requirements
Module: call_latch_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, giving the consecutive stable samples needed to accept a button level change; legal range 1..255.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port btn_n, input, [3:1], raw hall buttons, active low (0 = pressed); bit i = floor i; asynchronous to clk.
REQ-005 SHALL have port clr, input, [3:1], clear requests from the elevator controller, active high; bit i = floor i.
REQ-006 SHALL have port call, output, [3:1], latched pending calls, active high; feeds the controller's call input {call[3],call[2],call[1]}.
REQ-007 SHALL have port pressed, output, [3:1], debounced button level, active high.
REQ-008 SHALL have port call_any, output, 1, OR of call[3:1].

Function
REQ-009 SHALL treat each floor independently, with one debounce counter and one call FSM per floor.
REQ-010 SHALL debounce by counting consecutive clk edges at which the sampled level differs from pressed[i].
REQ-011 SHALL reset that counter to 0 on any sample equal to pressed[i].
REQ-012 SHALL toggle pressed[i] and zero the counter on the edge where the count reaches DEBOUNCE_CYCLES.
REQ-013 SHALL implement per-floor call FSM states IDLE, CALLED and HELD, with call[i] = 1 in CALLED and HELD and 0 in IDLE.
REQ-014 SHALL implement the following FSM transitions:
- IDLE -> CALLED on the edge after pressed[i] rises.
- CALLED -> IDLE when clr[i]=1 and pressed[i]=0.
- CALLED -> HELD when clr[i]=1 and pressed[i]=1 (clearing is deferred until release).
- HELD -> IDLE on the edge after pressed[i] falls.
- HELD ignores further clr[i].
REQ-015 SHALL let set dominate clear: pressed[i] rising while clr[i]=1 in IDLE enters CALLED.
REQ-016 SHALL ignore clr[i]=1 in IDLE and leave call[i] at 0.
REQ-017 SHALL reach call[i] = 1 exactly DEBOUNCE_CYCLES+1 edges after the first edge sampling btn_n[i]=0, without synchronizer (see REQ-024).
REQ-018 SHALL produce no call for a glitch shorter than DEBOUNCE_CYCLES samples.
REQ-019 SHALL service simultaneous presses and clears on several floors in the same cycle, with no cross-floor interaction.
REQ-020 SHALL saturate the counter at DEBOUNCE_CYCLES; it never wraps.

Reset
REQ-021 SHALL asynchronously force the following while rst_n=0, independent of clk:
- call=000, pressed=000, call_any=0.
- All FSMs to IDLE and all counters to 0.
- Synchronizer flops to 1 (released).
REQ-022 SHALL discard a press in progress when reset is asserted mid-debounce; after release of rst_n, debounce restarts from 0.
REQ-023 SHALL release reset synchronously with respect to state updates: the first counting edge is the first rising clk with rst_n=1.

Configuration
REQ-024 SHALL, with CALL_LATCH_SYNC_EN defined, pass btn_n through a 2-flop synchronizer before debounce, adding exactly 2 cycles to every latency in REQ-017 and REQ-014.
REQ-025 SHALL, without CALL_LATCH_SYNC_EN, sample btn_n directly; the integrator then guarantees synchronous inputs.

Structure
REQ-026 SHALL take NUM_FLOORS=3, the call FSM state enum (IDLE, CALLED, HELD) and the counter width constant (8) from shared package elevator_pkg.
REQ-027 SHALL place synchronizer and debounce in sub-module btn_debounce, one instance per floor; the call FSM stays in call_latch_ctrl.

Verification (DEBOUNCE_CYCLES=4, no CALL_LATCH_SYNC_EN unless stated)
REQ-028 SHALL cover: btn_n[3] 1->0 held -> pressed[3]=1 at edge 4, call[3]=1 and call_any=1 at edge 5, other bits 0.
REQ-029 SHALL cover: btn_n[2] low for 3 cycles then high -> pressed and call stay 000 throughout.
REQ-030 SHALL cover: call[3]=1 and btn still held, clr=100 for 1 cycle -> call[3] stays 1 (HELD); button released -> pressed[3]=0 after 4 edges, call[3]=0 one edge later.
REQ-031 SHALL cover: call=011 with buttons released, clr=011 for 1 cycle -> call=000 next edge; clr=100 in IDLE -> call[3] stays 0.
REQ-032 SHALL cover: with CALL_LATCH_SYNC_EN, btn_n=010 held -> call=101 at edge 7; then rst_n pulsed low mid-operation -> call=000 immediately, and again 101 at edge 7 after release.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared elevator constants and the per-floor call FSM state type.
package elevator_pkg;

    localparam int NUM_FLOORS = 3;
    localparam int CNT_W      = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALLED = 2'd1,
        HELD   = 2'd2
    } call_state_e;

endpackage

// File: rtl/btn_debounce.sv
// One hall button: optional 2-flop synchronizer then level debounce.
// Define CALL_LATCH_SYNC_EN to insert the synchronizer on btn_n_i.
module btn_debounce
    import elevator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n_i,
    output logic pressed_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES);

    logic             lvl;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pressed_q, pressed_d;

`ifdef CALL_LATCH_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], btn_n_i};
    end

    assign lvl = ~sync_q[1];
`else
    assign lvl = ~btn_n_i;
`endif

    // Count consecutive disagreeing samples; toggling at LIMIT keeps cnt saturated.
    always_comb begin
        cnt_d     = '0;
        pressed_d = pressed_q;
        if (lvl != pressed_q) begin
            if (cnt_q >= LIMIT - 1'b1) begin
                pressed_d = lvl;
                cnt_d     = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            pressed_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pressed_q <= pressed_d;
        end
    end

    assign pressed_o = pressed_q;

endmodule

// File: rtl/call_latch_ctrl.sv
// Hall-call latch: per-floor debounce plus IDLE/CALLED/HELD call FSM.
// Define CALL_LATCH_SYNC_EN to synchronize btn_n before debounce.
module call_latch_ctrl
    import elevator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS:1]   btn_n,
    input  logic [NUM_FLOORS:1]   clr,
    output logic [NUM_FLOORS:1]   call,
    output logic [NUM_FLOORS:1]   pressed,
    output logic                  call_any
);

    call_state_e state_q [1:NUM_FLOORS];
    call_state_e state_d [1:NUM_FLOORS];

    for (genvar f = 1; f <= NUM_FLOORS; f++) begin : g_floor
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk      (clk),
            .rst_n    (rst_n),
            .btn_n_i  (btn_n[f]),
            .pressed_o(pressed[f])
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) state_q[f] <= IDLE;
            else        state_q[f] <= state_d[f];
        end

        assign call[f] = (state_q[f] != IDLE);
    end

    // A clear while the button is still held is deferred until release.
    always_comb begin
        for (int f = 1; f <= NUM_FLOORS; f++) begin
            state_d[f] = state_q[f];
            case (state_q[f])
                IDLE: begin
                    if (pressed[f]) state_d[f] = CALLED;
                end
                CALLED: begin
                    if (clr[f]) state_d[f] = pressed[f] ? HELD : IDLE;
                end
                HELD: begin
                    if (!pressed[f]) state_d[f] = IDLE;
                end
                default: state_d[f] = IDLE;
            endcase
        end
    end

    assign call_any = |call;

endmodule

// File: tb/tb_call_latch_ctrl.sv
// Randomized bench for call_latch_ctrl against a behavioural call model.
// Define CALL_LATCH_SYNC_EN to check the synchronized build.
module tb_call_latch_ctrl;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:1] btn_n;
    logic [3:1] clr;
    logic [3:1] call;
    logic [3:1] pressed;
    logic       call_any;

    int total = 0;
    int bad   = 0;

    // model: run length of disagreeing samples, accepted level, latch, deferred clear
    int         run_len [1:3];
    bit         m_prs   [1:3];
    bit         m_call  [1:3];
    bit         m_defer [1:3];
    bit [3:1]   pipe0, pipe1;

    always #5 clk = ~clk;

    call_latch_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_n   (btn_n),
        .clr     (clr),
        .call    (call),
        .pressed (pressed),
        .call_any(call_any)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:1] exp_call();
        return {m_call[3], m_call[2], m_call[1]};
    endfunction

    function automatic logic [3:1] exp_prs();
        return {m_prs[3], m_prs[2], m_prs[1]};
    endfunction

    task automatic model_reset();
        for (int i = 1; i <= 3; i++) begin
            run_len[i] = 0;
            m_prs[i]   = 0;
            m_call[i]  = 0;
            m_defer[i] = 0;
        end
        pipe0 = 3'b111;
        pipe1 = 3'b111;
    endtask

    task automatic model_edge(input bit [3:1] b, input bit [3:1] c);
        bit [3:1] s;
`ifdef CALL_LATCH_SYNC_EN
        s     = pipe1;
        pipe1 = pipe0;
        pipe0 = b;
`else
        s = b;
`endif
        for (int i = 1; i <= 3; i++) begin
            // call latch reacts to the accepted level from before this edge
            if (!m_call[i]) begin
                if (m_prs[i]) m_call[i] = 1;
            end else if (m_defer[i]) begin
                if (!m_prs[i]) begin
                    m_call[i]  = 0;
                    m_defer[i] = 0;
                end
            end else if (c[i]) begin
                if (m_prs[i]) m_defer[i] = 1;
                else          m_call[i]  = 0;
            end
            if ((!s[i]) == m_prs[i]) begin
                run_len[i] = 0;
            end else begin
                run_len[i]++;
                if (run_len[i] >= DB) begin
                    m_prs[i]   = !m_prs[i];
                    run_len[i] = 0;
                end
            end
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".call"},    32'(call),     32'(exp_call()));
        check({tag, ".pressed"}, 32'(pressed),  32'(exp_prs()));
        check({tag, ".any"},     32'(call_any), 32'(|exp_call()));
    endtask

    // called at a negedge: drive, clock once, check at following negedge
    task automatic step(input logic [3:1] b, input logic [3:1] c,
                        input string tag);
        btn_n = b;
        clr   = c;
        @(posedge clk);
        model_edge(b, c);
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic reset_pulse(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check({tag, ".call"},    32'(call),     32'd0);
        check({tag, ".pressed"}, 32'(pressed),  32'd0);
        check({tag, ".any"},     32'(call_any), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        btn_n = 3'b111;
        clr   = 3'b000;
        rst_n = 1'b1;
        @(negedge clk);
        reset_pulse("rst");
        @(negedge clk);
        rst_n = 1'b1;

`ifndef CALL_LATCH_SYNC_EN
        for (int k = 1; k <= 5; k++) begin
            step(3'b011, 3'b000, "p3");
            if (k == 3) check("p3.prs_e3", 32'(pressed), 32'b000);
            if (k == 4) check("p3.prs_e4", 32'(pressed), 32'b100);
            if (k == 4) check("p3.call_e4", 32'(call), 32'b000);
            if (k == 5) check("p3.call_e5", 32'(call), 32'b100);
            if (k == 5) check("p3.any_e5", 32'(call_any), 32'd1);
        end
        step(3'b011, 3'b100, "hold");
        check("hold.call", 32'(call), 32'b100);
        step(3'b011, 3'b000, "hold2");
        for (int k = 1; k <= 5; k++) begin
            step(3'b111, 3'b000, "rel3");
            if (k == 4) check("rel3.prs_e4", 32'(pressed), 32'b000);
            if (k == 4) check("rel3.call_e4", 32'(call), 32'b100);
            if (k == 5) check("rel3.call_e5", 32'(call), 32'b000);
        end
        for (int k = 1; k <= 6; k++) begin
            step((k <= 3) ? 3'b101 : 3'b111, 3'b000, "glitch2");
            check("glitch2.prs", 32'(pressed), 32'b000);
            check("glitch2.call", 32'(call), 32'b000);
        end
        for (int k = 1; k <= 5; k++) step(3'b100, 3'b000, "p12");
        check("p12.call", 32'(call), 32'b011);
        for (int k = 1; k <= 4; k++) step(3'b111, 3'b000, "rel12");
        check("rel12.call", 32'(call), 32'b011);
        step(3'b111, 3'b011, "clr12");
        check("clr12.call", 32'(call), 32'b000);
        step(3'b111, 3'b100, "clr_idle");
        check("clr_idle.call", 32'(call), 32'b000);
`else
        for (int k = 1; k <= 7; k++) begin
            step(3'b010, 3'b000, "s13");
            if (k == 6) check("s13.call_e6", 32'(call), 32'b000);
            if (k == 7) check("s13.call_e7", 32'(call), 32'b101);
        end
        reset_pulse("srst");
        for (int k = 1; k <= 7; k++) begin
            step(3'b010, 3'b000, "s13b");
            if (k == 7) check("s13b.call_e7", 32'(call), 32'b101);
        end
        for (int k = 1; k <= 8; k++) step(3'b111, 3'b101, "srel");
`endif

        for (int n = 0; n < 600; n++) begin
            logic [3:1] b;
            logic [3:1] c;
            b = btn_n;
            for (int i = 1; i <= 3; i++) begin
                if ($urandom_range(0, 5) == 0) b[i] = ~b[i];
                c[i] = ($urandom_range(0, 3) == 0);
            end
            if (n == 300) begin
                reset_pulse("rnd_rst");
            end else begin
                step(b, c, "rnd");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
